serial_frame_receiver: RTL and testbench
========================================

Name: serial_frame_receiver

Overview:
- Serial-in, parallel-out frame receiver; counterpart of the parallel-load/shift-out transmit path in the register/counter library.
- Samples a framed serial line on a sample strobe: one start bit (0), WIDTH data bits, one stop bit (1).
- Assembles each frame into a parallel word held in an output buffer with a valid/ready handshake.
- Sits between a serial link and a parallel consumer.

Parameters:
- WIDTH, 4, data bits per frame and width of A_par (legal range 2..32).
- LSB_FIRST, 0, 0 = first data bit is the MSB (shift left); 1 = first data bit is the LSB (shift right).

Ports:
- CLK  input  1  single clock, rising edge.
- Clear  input  1  asynchronous, active-high reset.
- bit_en  input  1  sample strobe; ser_in is sampled only on CLK edges where bit_en=1.
- ser_in  input  1  serial line; idles at 1.
- data_ready  input  1  consumer accepts A_par when data_ready=1 and data_valid=1.
- err_clr  input  1  synchronous clear of frame_err and overrun.
- A_par  output  WIDTH  received word (holding buffer).
- data_valid  output  1  A_par holds an unconsumed word.
- busy  output  1  1 while in DATA or STOP.
- frame_err  output  1  sticky: stop bit sampled as 0.
- overrun  output  1  sticky: good frame arrived while buffer full and not being consumed.

Behaviour:
- Reset (Clear=1, asynchronous): A_par=0, data_valid=0, busy=0, frame_err=0, overrun=0, state=IDLE, shift register=0, bit counter=0. Reset takes precedence over everything, including mid-frame; the partial frame is discarded.
- All state changes happen only on CLK edges where bit_en=1, except the handshake and err_clr, which act on every CLK edge.
- IDLE: ser_in=0 -> DATA, bit counter=0. ser_in=1 -> stay.
- DATA: shift ser_in into the internal shift register.
  - LSB_FIRST=0: sh <= {sh[WIDTH-2:0], ser_in}.
  - LSB_FIRST=1: sh <= {ser_in, sh[WIDTH-1:1]}.
  - Counter increments; after the WIDTH-th data bit -> STOP.
- STOP, ser_in=1 (good frame):
  - Buffer free (data_valid=0) or being consumed this edge: A_par <= sh, data_valid=1.
  - Otherwise: word dropped, A_par unchanged, overrun<=1.
  - Either case -> IDLE.
- STOP, ser_in=0: frame_err<=1, word dropped, -> IDLE. The 0 is not treated as a new start bit.
- busy = (state != IDLE).
- Handshake:
  - data_valid=1 and data_ready=1 at an edge -> data_valid<=0, unless a good stop bit is accepted on the same edge, in which case A_par loads the new word and data_valid stays 1.
  - A_par is held stable while data_valid=1 and not consumed.
- Latency: data_valid rises at the CLK edge that samples the stop bit. The word is visible in the cycle after that edge. A frame takes WIDTH+2 strobes from the start bit.
- err_clr=1 clears frame_err and overrun. If a new error occurs on the same edge, the set wins.
- bit_en gaps of any length are legal; the state machine simply holds.
- Back-to-back frames are legal: a start bit may be sampled on the strobe directly after the stop bit.
- A_par is not cleared on consume; it retains its last value.

Test Plan:
- Reset then idle: Clear pulse, ser_in=1 with bit_en every cycle for 10 cycles -> all outputs 0, busy=0 throughout.
- WIDTH=4, LSB_FIRST=0, strobes every cycle, bits 0,1,0,1,1,1 -> busy high for 5 strobes; A_par=4'b1011 and data_valid=1 after the stop edge; data_ready=1 for one cycle -> data_valid=0, A_par stays 4'b1011.
- LSB_FIRST=1, bits 0,1,0,1,1,1 with bit_en every 3rd cycle -> A_par=4'b1101; no state change on non-strobe cycles.
- Frame error: bits 0,1,1,1,1,0 -> frame_err=1, data_valid=0, state IDLE; next frame 0,0,0,1,1,1 -> A_par=4'b0011; err_clr pulse -> frame_err=0.
- Overrun and simultaneous consume:
  - Frame A=4'b1001 left unconsumed, then frame B=4'b0110 -> overrun=1, A_par=4'b1001.
  - Frame C=4'b1111 with data_ready=1 on its stop edge -> A_par=4'b1111, data_valid stays 1.
- Reset mid-frame: Clear asserted asynchronously after 2 data bits -> outputs 0 immediately; after release, a full frame 0,1,1,0,0,1 -> A_par=4'b1100.

Source files
------------

// File: rtl/serial_frame_receiver_if.sv
// serial_frame_receiver_if
//   Bundles the serial-side inputs and the parallel-side outputs of the
//   frame receiver.
//   master : the receiver itself (samples the line, drives the word buffer)
//   slave  : the link/consumer side (drives the line, handshake and clears)
//   Signals:
//     bit_en      sample strobe
//     ser_in      serial line, idles at 1
//     data_ready  consumer accepts A_par when data_valid=1
//     err_clr     synchronous clear of the sticky error flags
//     A_par       received word (holding buffer)
//     data_valid  A_par holds an unconsumed word
//     busy        frame in progress (DATA or STOP)
//     frame_err   sticky: stop bit sampled as 0
//     overrun     sticky: good frame dropped because the buffer was full
interface serial_frame_receiver_if #(
    parameter int WIDTH = 4
);
    logic             bit_en;
    logic             ser_in;
    logic             data_ready;
    logic             err_clr;
    logic [WIDTH-1:0] A_par;
    logic             data_valid;
    logic             busy;
    logic             frame_err;
    logic             overrun;

    modport master (
        input  bit_en, ser_in, data_ready, err_clr,
        output A_par, data_valid, busy, frame_err, overrun
    );

    modport slave (
        output bit_en, ser_in, data_ready, err_clr,
        input  A_par, data_valid, busy, frame_err, overrun
    );
endinterface

// File: rtl/serial_frame_receiver.sv
// serial_frame_receiver
//   Serial-in, parallel-out frame receiver. A frame is one start bit (0),
//   WIDTH data bits and one stop bit (1), each sampled on a CLK edge with
//   bit_en=1. A good frame is moved into the A_par holding buffer, which is
//   handed to the consumer with a valid/ready handshake.
//   Ports:
//     CLK    clock, rising edge
//     Clear  asynchronous, active-high reset
//     bus    serial_frame_receiver_if.master (line, handshake, status)
//   Parameters:
//     WIDTH      data bits per frame (2..32)
//     LSB_FIRST  0: first data bit lands in the MSB; 1: first data bit is the LSB
//
//   state | meaning
//   ------+-------------------------------------------------
//   IDLE  | line idle, waiting for a start bit (0)
//   DATA  | shifting in WIDTH data bits
//   STOP  | next strobe samples the stop bit
module serial_frame_receiver #(
    parameter int WIDTH     = 4,
    parameter bit LSB_FIRST = 1'b0
) (
    input  logic                   CLK,
    input  logic                   Clear,
    serial_frame_receiver_if.master bus
);
    localparam int             CW       = $clog2(WIDTH);
    localparam logic [CW-1:0]  LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] sh_q;
    logic [WIDTH-1:0] sh_next;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] a_par_q;
    logic             data_valid_q;
    logic             busy_q;
    logic             frame_err_q;
    logic             overrun_q;
    logic             consume;

    generate
        if (LSB_FIRST) begin : g_lsb_first
            assign sh_next = {bus.ser_in, sh_q[WIDTH-1:1]};
        end else begin : g_msb_first
            assign sh_next = {sh_q[WIDTH-2:0], bus.ser_in};
        end
    endgenerate

    assign consume = data_valid_q & bus.data_ready;

    always_ff @(posedge CLK or posedge Clear) begin
        if (Clear) begin
            state_q      <= IDLE;
            sh_q         <= '0;
            cnt_q        <= '0;
            a_par_q      <= '0;
            data_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            // Handshake and error clear act every edge; a frame event on the
            // same edge is assigned later and therefore overrides them.
            if (consume) begin
                data_valid_q <= 1'b0;
            end
            if (bus.err_clr) begin
                frame_err_q <= 1'b0;
                overrun_q   <= 1'b0;
            end

            if (bus.bit_en) begin
                unique case (state_q)
                    IDLE: begin
                        if (!bus.ser_in) begin
                            state_q <= DATA;
                            busy_q  <= 1'b1;
                            cnt_q   <= '0;
                        end
                    end
                    DATA: begin
                        sh_q  <= sh_next;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == LAST_BIT) begin
                            state_q <= STOP;
                        end
                    end
                    STOP: begin
                        // A 0 stop bit is an error, never a new start bit.
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        if (bus.ser_in) begin
                            if (!data_valid_q || consume) begin
                                a_par_q      <= sh_q;
                                data_valid_q <= 1'b1;
                            end else begin
                                overrun_q <= 1'b1;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.A_par      = a_par_q;
    assign bus.data_valid = data_valid_q;
    assign bus.busy       = busy_q;
    assign bus.frame_err  = frame_err_q;
    assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_serial_frame_receiver.sv
`timescale 1ns/1ps
module tb_serial_frame_receiver;
    localparam int W = 4;

    logic CLK = 1'b0;
    logic Clear;
    always #5 CLK = ~CLK;

    // Two receivers see identical stimulus: one MSB-first, one LSB-first.
    serial_frame_receiver_if #(.WIDTH(W)) if_msb ();
    serial_frame_receiver_if #(.WIDTH(W)) if_lsb ();

    serial_frame_receiver #(.WIDTH(W), .LSB_FIRST(1'b0)) dut_msb (
        .CLK   (CLK),
        .Clear (Clear),
        .bus   (if_msb.master)
    );

    serial_frame_receiver #(.WIDTH(W), .LSB_FIRST(1'b1)) dut_lsb (
        .CLK   (CLK),
        .Clear (Clear),
        .bus   (if_lsb.master)
    );

    int n_cmp = 0;
    int n_bad = 0;

    // Frame-level reference model.
    logic [W-1:0] m_msb;
    logic [W-1:0] m_lsb;
    bit           m_valid;
    bit           m_ferr;
    bit           m_ovr;

    function automatic logic [W-1:0] reverse_bits(input logic [W-1:0] v);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = v[W-1-i];
        return r;
    endfunction

    task automatic drive(input bit en, input bit s, input bit rdy, input bit clr);
        if_msb.bit_en = en; if_msb.ser_in = s; if_msb.data_ready = rdy; if_msb.err_clr = clr;
        if_lsb.bit_en = en; if_lsb.ser_in = s; if_lsb.data_ready = rdy; if_lsb.err_clr = clr;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic strobe(input bit s, input bit rdy, input bit clr);
        @(negedge CLK);
        drive(1'b1, s, rdy, clr);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // Non-strobe cycles with a random line value, which must be ignored.
    task automatic gap(input int n);
        for (int g = 0; g < n; g++) begin
            @(negedge CLK);
            drive(1'b0, 1'($urandom % 2), 1'b0, 1'b0);
            tick();
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0);
    endtask

    // word[W-1] is transmitted first.
    task automatic send_frame(input logic [W-1:0] word, input bit stop, input int max_gap,
                              input bit rdy_stop, input bit clr_stop);
        bit cons;
        strobe(1'b0, 1'b0, 1'b0);
        gap(int'($urandom_range(max_gap, 0)));
        for (int i = W - 1; i >= 0; i--) begin
            strobe(word[i], 1'b0, 1'b0);
            gap(int'($urandom_range(max_gap, 0)));
        end
        strobe(stop, rdy_stop, clr_stop);
        cons = m_valid && rdy_stop;
        if (clr_stop) begin m_ferr = 0; m_ovr = 0; end
        if (stop) begin
            if (!m_valid || cons) begin
                m_msb = word; m_lsb = reverse_bits(word); m_valid = 1;
            end else begin
                m_ovr = 1;
            end
        end else begin
            m_ferr = 1;
            if (cons) m_valid = 0;
        end
    endtask

    task automatic consume_word();
        @(negedge CLK);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        m_valid = 0;
    endtask

    task automatic clear_errors();
        @(negedge CLK);
        drive(1'b0, 1'b1, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        m_ferr = 0; m_ovr = 0;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        Clear = 1'b1;
        @(negedge CLK);
        Clear = 1'b0;
        m_msb = '0; m_lsb = '0; m_valid = 0; m_ferr = 0; m_ovr = 0;
    endtask

    task automatic test_reset();
        do_reset();
        for (int c = 0; c < 10; c++) begin
            strobe(1'b1, 1'b0, 1'b0);
            n_cmp++;
            if (if_msb.busy !== 1'b0 || if_lsb.busy !== 1'b0) begin
                n_bad++;
                $display("FAIL reset_idle_busy cycle %0d: got %b/%b want 0", c, if_msb.busy, if_lsb.busy);
            end
            n_cmp++;
            if ({if_msb.A_par, if_msb.data_valid, if_msb.frame_err, if_msb.overrun,
                 if_lsb.A_par, if_lsb.data_valid, if_lsb.frame_err, if_lsb.overrun} !== '0) begin
                n_bad++;
                $display("FAIL reset_idle_outputs cycle %0d: got A_par=%h/%h valid=%b/%b ferr=%b/%b ovr=%b/%b want all 0",
                         c, if_msb.A_par, if_lsb.A_par, if_msb.data_valid, if_lsb.data_valid,
                         if_msb.frame_err, if_lsb.frame_err, if_msb.overrun, if_lsb.overrun);
            end
        end
    endtask

    task automatic test_basic();
        logic [5:0] seq;
        bit exp_busy;
        seq = 6'b010111;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            strobe(seq[5-k], 1'b0, 1'b0);
            exp_busy = (k < 5);
            n_cmp++;
            if (if_msb.busy !== exp_busy) begin
                n_bad++;
                $display("FAIL basic_busy strobe %0d: got %b want %b", k, if_msb.busy, exp_busy);
            end
        end
        n_cmp++;
        if (if_msb.A_par !== 4'b1011 || if_lsb.A_par !== 4'b1101 || if_msb.data_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL basic_word: got msb=%b lsb=%b valid=%b want 1011 1101 1",
                     if_msb.A_par, if_lsb.A_par, if_msb.data_valid);
        end
        m_msb = 4'b1011; m_lsb = 4'b1101; m_valid = 1;
        consume_word();
        n_cmp++;
        if (if_msb.data_valid !== 1'b0 || if_lsb.data_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL basic_consume_valid: got %b/%b want 0", if_msb.data_valid, if_lsb.data_valid);
        end
        n_cmp++;
        if (if_msb.A_par !== 4'b1011 || if_lsb.A_par !== 4'b1101) begin
            n_bad++;
            $display("FAIL basic_hold_after_consume: got %b/%b want 1011/1101", if_msb.A_par, if_lsb.A_par);
        end
    endtask

    task automatic test_gapped();
        logic [5:0] seq;
        bit exp_busy;
        seq = 6'b010111;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            strobe(seq[5-k], 1'b0, 1'b0);
            gap(2);
            exp_busy = (k < 5);
            n_cmp++;
            if (if_lsb.busy !== exp_busy || if_msb.busy !== exp_busy || if_lsb.data_valid !== (k == 5)) begin
                n_bad++;
                $display("FAIL gapped_hold strobe %0d: got busy=%b/%b valid=%b want busy=%b valid=%b",
                         k, if_msb.busy, if_lsb.busy, if_lsb.data_valid, exp_busy, (k == 5));
            end
        end
        n_cmp++;
        if (if_lsb.A_par !== 4'b1101 || if_msb.A_par !== 4'b1011) begin
            n_bad++;
            $display("FAIL gapped_word: got lsb=%b msb=%b want 1101 1011", if_lsb.A_par, if_msb.A_par);
        end
        m_msb = 4'b1011; m_lsb = 4'b1101; m_valid = 1;
    endtask

    task automatic test_frame_err();
        do_reset();
        send_frame(4'b1111, 1'b0, 0, 1'b0, 1'b0);
        n_cmp++;
        if (if_msb.frame_err !== 1'b1 || if_msb.data_valid !== 1'b0 || if_msb.busy !== 1'b0) begin
            n_bad++;
            $display("FAIL ferr_set: got ferr=%b valid=%b busy=%b want 1 0 0",
                     if_msb.frame_err, if_msb.data_valid, if_msb.busy);
        end
        send_frame(4'b0011, 1'b1, 0, 1'b0, 1'b0);
        n_cmp++;
        if (if_msb.A_par !== 4'b0011 || if_lsb.A_par !== 4'b1100 || if_msb.data_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL ferr_next_frame: got msb=%b lsb=%b valid=%b want 0011 1100 1",
                     if_msb.A_par, if_lsb.A_par, if_msb.data_valid);
        end
        n_cmp++;
        if (if_msb.frame_err !== 1'b1) begin
            n_bad++;
            $display("FAIL ferr_sticky: got %b want 1", if_msb.frame_err);
        end
        clear_errors();
        n_cmp++;
        if (if_msb.frame_err !== 1'b0 || if_lsb.frame_err !== 1'b0) begin
            n_bad++;
            $display("FAIL ferr_clear: got %b/%b want 0", if_msb.frame_err, if_lsb.frame_err);
        end
        // Clear and a new error on the same edge: the error must survive.
        send_frame(4'b0101, 1'b0, 1, 1'b0, 1'b1);
        n_cmp++;
        if (if_msb.frame_err !== 1'b1 || if_msb.A_par !== 4'b0011) begin
            n_bad++;
            $display("FAIL ferr_set_wins: got ferr=%b A_par=%b want 1 0011", if_msb.frame_err, if_msb.A_par);
        end
    endtask

    task automatic test_overrun();
        do_reset();
        send_frame(4'b1001, 1'b1, 1, 1'b0, 1'b0);
        send_frame(4'b0110, 1'b1, 1, 1'b0, 1'b0);
        n_cmp++;
        if (if_msb.overrun !== 1'b1 || if_msb.A_par !== 4'b1001 || if_msb.data_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_set: got ovr=%b A_par=%b valid=%b want 1 1001 1",
                     if_msb.overrun, if_msb.A_par, if_msb.data_valid);
        end
        send_frame(4'b1111, 1'b1, 0, 1'b1, 1'b0);
        n_cmp++;
        if (if_msb.A_par !== 4'b1111 || if_msb.data_valid !== 1'b1 || if_msb.overrun !== 1'b1) begin
            n_bad++;
            $display("FAIL overrun_consume_same_edge: got A_par=%b valid=%b ovr=%b want 1111 1 1",
                     if_msb.A_par, if_msb.data_valid, if_msb.overrun);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        send_frame(4'b1010, 1'b1, 0, 1'b0, 1'b0);
        strobe(1'b0, 1'b0, 1'b0);
        strobe(1'b1, 1'b0, 1'b0);
        strobe(1'b1, 1'b0, 1'b0);
        #2 Clear = 1'b1;
        #1;
        n_cmp++;
        if ({if_msb.A_par, if_msb.data_valid, if_msb.busy, if_lsb.A_par, if_lsb.data_valid, if_lsb.busy} !== '0) begin
            n_bad++;
            $display("FAIL reset_mid_async: got A_par=%h/%h valid=%b/%b busy=%b/%b want all 0",
                     if_msb.A_par, if_lsb.A_par, if_msb.data_valid, if_lsb.data_valid, if_msb.busy, if_lsb.busy);
        end
        @(negedge CLK);
        Clear = 1'b0;
        m_msb = '0; m_lsb = '0; m_valid = 0; m_ferr = 0; m_ovr = 0;
        send_frame(4'b1100, 1'b1, 0, 1'b0, 1'b0);
        n_cmp++;
        if (if_msb.A_par !== 4'b1100 || if_lsb.A_par !== 4'b0011 || if_msb.data_valid !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_mid_next_frame: got msb=%b lsb=%b valid=%b want 1100 0011 1",
                     if_msb.A_par, if_lsb.A_par, if_msb.data_valid);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] w;
        do_reset();
        for (int f = 0; f < 6; f++) begin
            w = W'($urandom);
            send_frame(w, 1'b1, 0, 1'b1, 1'b0);
            n_cmp++;
            if (if_msb.A_par !== m_msb || if_lsb.A_par !== m_lsb || if_msb.data_valid !== 1'b1
                || if_msb.overrun !== 1'b0) begin
                n_bad++;
                $display("FAIL b2b frame %0d: got msb=%h lsb=%h valid=%b ovr=%b want %h %h 1 0",
                         f, if_msb.A_par, if_lsb.A_par, if_msb.data_valid, if_msb.overrun, m_msb, m_lsb);
            end
        end
    endtask

    task automatic test_random();
        logic [W-1:0] w;
        bit stop;
        do_reset();
        for (int f = 0; f < 60; f++) begin
            w    = W'($urandom);
            stop = ($urandom % 8) != 0;
            send_frame(w, stop, 2, ($urandom % 4) == 0, ($urandom % 8) == 0);
            n_cmp++;
            if (if_msb.A_par !== m_msb || if_lsb.A_par !== m_lsb) begin
                n_bad++;
                $display("FAIL rnd_apar frame %0d: got %h/%h want %h/%h", f, if_msb.A_par, if_lsb.A_par, m_msb, m_lsb);
            end
            n_cmp++;
            if (if_msb.data_valid !== m_valid || if_lsb.data_valid !== m_valid) begin
                n_bad++;
                $display("FAIL rnd_valid frame %0d: got %b/%b want %b", f, if_msb.data_valid, if_lsb.data_valid, m_valid);
            end
            n_cmp++;
            if (if_msb.frame_err !== m_ferr || if_msb.overrun !== m_ovr || if_msb.busy !== 1'b0) begin
                n_bad++;
                $display("FAIL rnd_flags frame %0d: got ferr=%b ovr=%b busy=%b want %b %b 0",
                         f, if_msb.frame_err, if_msb.overrun, if_msb.busy, m_ferr, m_ovr);
            end
            if (($urandom % 2) == 0) begin
                consume_word();
                n_cmp++;
                if (if_msb.data_valid !== 1'b0 || if_msb.A_par !== m_msb) begin
                    n_bad++;
                    $display("FAIL rnd_consume frame %0d: got valid=%b A_par=%h want 0 %h",
                             f, if_msb.data_valid, if_msb.A_par, m_msb);
                end
            end
            if (($urandom % 7) == 0) clear_errors();
        end
    endtask

    initial begin
        Clear = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b0);
        m_msb = '0; m_lsb = '0; m_valid = 0; m_ferr = 0; m_ovr = 0;
        test_reset();
        test_basic();
        test_gapped();
        test_frame_err();
        test_overrun();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got no completion want completion");
        $fatal(1, "watchdog expired");
    end
endmodule
